// File: rtl/ctrl_arb_pkg.sv
// Shared types and constants for the drive-command arbiter: FSM state, direction codes, width helpers.
package ctrl_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int DIR_W = 3;
    localparam logic [DIR_W-1:0] CMD_STOP  = 3'd0;
    localparam logic [DIR_W-1:0] CMD_FWD   = 3'd1;
    localparam logic [DIR_W-1:0] CMD_REV   = 3'd2;
    localparam logic [DIR_W-1:0] CMD_LEFT  = 3'd3;
    localparam logic [DIR_W-1:0] CMD_RIGHT = 3'd4;

    // Counter width able to hold values 0..n-1, never below one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of the packed per-source command bus.
    function automatic int pack_w(input int n_src, input int cmd_w);
        return n_src * cmd_w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant: fixed priority (lowest index) or round-robin scan starting at 'start'.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    input  logic             rr_mode,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] scan_idx;
    logic             found;

    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        scan_idx = '0;
        found    = 1'b0;
        for (int k = 0; k < N; k++) begin
            scan_idx = rr_mode ? IDX_W'((int'(start) + k) % N) : IDX_W'(k);
            if (!found && req[scan_idx]) begin
                found         = 1'b1;
                gnt[scan_idx] = 1'b1;
                gnt_idx       = scan_idx;
            end
        end
    end

endmodule

// File: rtl/control_arbiter.sv
// Drive-command arbiter: one source owns the output for a hold window, watchdog forces SAFE_CMD.
// Optional CTRL_ARB_DEBOUNCE_EN: a strobe only requests when it repeats that source's previous command.
module control_arbiter
    import ctrl_arb_pkg::*;
#(
    parameter int N_SRC          = 3,
    parameter int CMD_W          = 3,
    parameter int HOLD_CYCLES    = 25_000_000,
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int SAFE_CMD       = int'(CMD_STOP),
    parameter int RR_MODE        = 0
) (
    input  logic                             clk_50,
    input  logic                             rst_n,
    input  logic [N_SRC-1:0]                 src_valid,
    input  logic [pack_w(N_SRC, CMD_W)-1:0]  src_cmd,
    input  logic [N_SRC-1:0]                 src_enable,
    output logic [CMD_W-1:0]                 cmd,
    output logic                             cmd_valid,
    output logic [$clog2(N_SRC)-1:0]         owner,
    output logic                             owner_active,
    output logic                             timeout_flag
);

    localparam int OWN_W  = $clog2(N_SRC);
    localparam int HOLD_W = cnt_w(HOLD_CYCLES);
    localparam int TO_W   = cnt_w(TIMEOUT_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TO_W-1:0]   WD_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CMD_W-1:0]  SAFE      = CMD_W'(SAFE_CMD);
    localparam logic [OWN_W-1:0]  LAST_IDX  = OWN_W'(N_SRC - 1);

    arb_state_e                    state_q, state_d;
    logic [CMD_W-1:0]              cmd_q, cmd_d;
    logic                          cmd_valid_q, cmd_valid_d;
    logic [OWN_W-1:0]              owner_q, owner_d;
    logic                          flag_q, flag_d;
    logic [HOLD_W-1:0]             hold_q, hold_d;
    logic [TO_W-1:0]               wd_q, wd_d;
    logic                          wd_done_q, wd_done_d;
    logic [OWN_W-1:0]              last_q, last_d;

    logic [N_SRC-1:0][CMD_W-1:0]   cmds;
    logic [N_SRC-1:0]              deb_ok;
    logic [N_SRC-1:0]              req;
    logic [N_SRC-1:0]              gnt;
    logic [OWN_W-1:0]              gnt_idx;
    logic [OWN_W-1:0]              rr_start;
    logic                          gnt_any;
    logic                          wd_expire;
    logic                          do_grant, do_accept, do_fire;

    assign cmds = src_cmd;

`ifdef CTRL_ARB_DEBOUNCE_EN
    logic [N_SRC-1:0][CMD_W-1:0] last_val_q;

    for (genvar i = 0; i < N_SRC; i++) begin : g_deb
        always_ff @(posedge clk_50 or negedge rst_n) begin
            if (!rst_n)
                last_val_q[i] <= SAFE;
            else if (src_valid[i])
                last_val_q[i] <= cmds[i];
        end
        assign deb_ok[i] = (cmds[i] == last_val_q[i]);
    end
`else
    assign deb_ok = '1;
`endif

    assign req      = src_valid & src_enable & deb_ok;
    assign rr_start = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;
    assign gnt_any  = |gnt;

    rr_arbiter #(
        .N     (N_SRC),
        .IDX_W (OWN_W)
    ) u_rr_arbiter (
        .req     (req),
        .start   (rr_start),
        .rr_mode (RR_MODE != 0),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The watchdog saturates at its last count; wd_done stops it re-firing until the next grant.
    assign wd_expire = (wd_q == WD_LAST) && !wd_done_q;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        owner_d     = owner_q;
        flag_d      = flag_q;
        hold_d      = hold_q;
        wd_d        = (wd_q == WD_LAST) ? wd_q : wd_q + 1'b1;
        wd_done_d   = wd_done_q;
        last_d      = last_q;
        do_grant    = 1'b0;
        do_accept   = 1'b0;
        do_fire     = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_any)        do_grant = 1'b1;
                else if (wd_expire) do_fire  = 1'b1;
            end
            OWN: begin
                if (!src_enable[owner_q]) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (hold_q != '0) begin
                    if (req[owner_q]) begin
                        do_accept = 1'b1;
                    end else begin
                        hold_d = hold_q - 1'b1;
                        if (wd_expire) do_fire = 1'b1;
                    end
                end else if (gnt_any) begin
                    do_grant = 1'b1;
                end else if (wd_expire) begin
                    do_fire = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_grant) begin
            state_d     = OWN;
            owner_d     = gnt_idx;
            last_d      = gnt_idx;
            cmd_d       = cmds[gnt_idx];
            cmd_valid_d = 1'b1;
            hold_d      = HOLD_LOAD;
            wd_d        = '0;
            wd_done_d   = 1'b0;
            flag_d      = 1'b0;
        end
        if (do_accept) begin
            cmd_d       = cmds[owner_q];
            cmd_valid_d = 1'b1;
            hold_d      = HOLD_LOAD;
            wd_d        = '0;
            flag_d      = 1'b0;
        end
        if (do_fire) begin
            state_d     = IDLE;
            cmd_d       = SAFE;
            cmd_valid_d = 1'b1;
            hold_d      = '0;
            flag_d      = 1'b1;
            wd_done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_q       <= SAFE;
            cmd_valid_q <= 1'b0;
            owner_q     <= '0;
            flag_q      <= 1'b0;
            hold_q      <= '0;
            wd_q        <= '0;
            wd_done_q   <= 1'b0;
            last_q      <= LAST_IDX;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            owner_q     <= owner_d;
            flag_q      <= flag_d;
            hold_q      <= hold_d;
            wd_q        <= wd_d;
            wd_done_q   <= wd_done_d;
            last_q      <= last_d;
        end
    end

    assign cmd          = cmd_q;
    assign cmd_valid    = cmd_valid_q;
    assign owner        = owner_q;
    assign owner_active = (state_q == OWN);
    assign timeout_flag = flag_q;

endmodule

// File: tb/tb_control_arbiter.sv
// Directed bench: fixed-priority and round-robin instances driven by shared inputs.
module tb_control_arbiter;

    logic       clk_50 = 1'b0;
    logic       rst_n  = 1'b0;
    logic [2:0] src_valid  = '0;
    logic [8:0] src_cmd    = '0;
    logic [2:0] src_enable = 3'b111;

    logic [2:0] fp_cmd, rr_cmd;
    logic       fp_cv, rr_cv;
    logic [1:0] fp_owner, rr_owner;
    logic       fp_oa, rr_oa;
    logic       fp_to, rr_to;

    int checks = 0;
    int errors = 0;

    always #5 clk_50 = ~clk_50;

    control_arbiter #(.N_SRC(3), .CMD_W(3), .HOLD_CYCLES(8), .TIMEOUT_CYCLES(20),
                      .SAFE_CMD(0), .RR_MODE(0)) dut_fp (
        .clk_50(clk_50), .rst_n(rst_n), .src_valid(src_valid), .src_cmd(src_cmd),
        .src_enable(src_enable), .cmd(fp_cmd), .cmd_valid(fp_cv), .owner(fp_owner),
        .owner_active(fp_oa), .timeout_flag(fp_to));

    control_arbiter #(.N_SRC(3), .CMD_W(3), .HOLD_CYCLES(8), .TIMEOUT_CYCLES(20),
                      .SAFE_CMD(0), .RR_MODE(1)) dut_rr (
        .clk_50(clk_50), .rst_n(rst_n), .src_valid(src_valid), .src_cmd(src_cmd),
        .src_enable(src_enable), .cmd(rr_cmd), .cmd_valid(rr_cv), .owner(rr_owner),
        .owner_active(rr_oa), .timeout_flag(rr_to));

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic set_cmds(input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2);
        src_cmd = {c2, c1, c0};
    endtask

    // Called at a negedge; returns at the negedge right after the sampling posedge.
    task automatic pulse(input logic [2:0] v);
        src_valid = v;
        @(negedge clk_50);
        src_valid = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src_valid = '0;
        src_enable = 3'b111;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        logic [1:0] rr_exp_owner [4];
        logic [2:0] rr_exp_cmd   [4];
        rr_exp_owner = '{2'd0, 2'd1, 2'd2, 2'd0};
        rr_exp_cmd   = '{3'd1, 3'd2, 3'd3, 3'd1};

        // Reset values
        idle(2);
        chk("rst_cmd",   fp_cmd,   0);
        chk("rst_cv",    fp_cv,    0);
        chk("rst_owner", fp_owner, 0);
        chk("rst_oa",    fp_oa,    0);
        chk("rst_to",    fp_to,    0);
        rst_n = 1'b1;
        idle(1);
        chk("rst_release_cv", fp_cv, 0);

`ifdef CTRL_ARB_DEBOUNCE_EN
        // First strobe only primes the last-value register, the repeat is granted
        set_cmds(3'd3, 3'd0, 3'd0);
        pulse(3'b001);
        chk("deb_first_oa", fp_oa, 0);
        chk("deb_first_cv", fp_cv, 0);
        pulse(3'b001);
        chk("deb_second_oa",  fp_oa,  1);
        chk("deb_second_cmd", fp_cmd, 3);
        chk("deb_second_cv",  fp_cv,  1);

        do_reset();
        set_cmds(3'd3, 3'd0, 3'd0);
        pulse(3'b001);
        chk("deb_a_oa", fp_oa, 0);
        set_cmds(3'd5, 3'd0, 3'd0);
        pulse(3'b001);
        chk("deb_b_oa",  fp_oa,  0);
        chk("deb_b_cv",  fp_cv,  0);
        chk("deb_b_cmd", fp_cmd, 0);
`else
        // Fixed priority: src1 beats src2
        set_cmds(3'd0, 3'd5, 3'd6);
        pulse(3'b110);
        chk("fp_owner", fp_owner, 1);
        chk("fp_cmd",   fp_cmd,   5);
        chk("fp_cv",    fp_cv,    1);
        chk("fp_oa",    fp_oa,    1);
        chk("rr_first_owner", rr_owner, 1);
        idle(1);
        chk("fp_cv_single", fp_cv, 0);
        chk("fp_cmd_held",  fp_cmd, 5);

        // Hold window: intruder dropped at +3, wins at +9
        do_reset();
        set_cmds(3'd1, 3'd0, 3'd2);
        pulse(3'b001);
        chk("hold_grant_owner", fp_owner, 0);
        idle(2);
        pulse(3'b100);
        chk("hold_drop_owner", fp_owner, 0);
        chk("hold_drop_cmd",   fp_cmd,   1);
        chk("hold_drop_cv",    fp_cv,    0);
        idle(5);
        pulse(3'b100);
        chk("hold_open_owner", fp_owner, 2);
        chk("hold_open_cmd",   fp_cmd,   2);
        chk("hold_open_cv",    fp_cv,    1);
        pulse(3'b100);
        chk("same_cmd_cv",    fp_cv,    1);
        chk("same_cmd_owner", fp_owner, 2);

        // Round-robin rotation vs fixed priority
        do_reset();
        set_cmds(3'd1, 3'd2, 3'd3);
        for (int i = 0; i < 4; i++) begin
            pulse(3'b111);
            chk("rr_owner", rr_owner, rr_exp_owner[i]);
            chk("rr_cmd",   rr_cmd,   rr_exp_cmd[i]);
            chk("fp_static_owner", fp_owner, 0);
            idle(9);
        end

        // Watchdog
        do_reset();
        set_cmds(3'd4, 3'd0, 3'd0);
        pulse(3'b001);
        chk("wd_grant_cmd", fp_cmd, 4);
        idle(19);
        chk("wd_pre_cmd", fp_cmd, 4);
        chk("wd_pre_to",  fp_to,  0);
        idle(1);
        chk("wd_fire_cmd", fp_cmd, 0);
        chk("wd_fire_cv",  fp_cv,  1);
        chk("wd_fire_to",  fp_to,  1);
        chk("wd_fire_oa",  fp_oa,  0);
        idle(1);
        chk("wd_single_cv", fp_cv, 0);
        idle(25);
        chk("wd_sat_cv", fp_cv, 0);
        chk("wd_sat_to", fp_to, 1);
        pulse(3'b001);
        chk("wd_clear_to",  fp_to,  0);
        chk("wd_clear_oa",  fp_oa,  1);
        chk("wd_clear_cmd", fp_cmd, 4);
        // Strobe on the expiry cycle wins over the safe command
        idle(19);
        set_cmds(3'd3, 3'd0, 3'd0);
        pulse(3'b001);
        chk("wd_race_cmd", fp_cmd, 3);
        chk("wd_race_to",  fp_to,  0);
        chk("wd_race_oa",  fp_oa,  1);

        // Owner masked mid-hold
        do_reset();
        set_cmds(3'd0, 3'd2, 3'd0);
        pulse(3'b010);
        chk("mask_grant_owner", fp_owner, 1);
        idle(1);
        src_enable = 3'b101;
        idle(1);
        chk("mask_oa",  fp_oa,  0);
        chk("mask_cv",  fp_cv,  0);
        chk("mask_cmd", fp_cmd, 2);
        src_enable = 3'b111;

        // Reset mid-hold clears outputs immediately
        pulse(3'b010);
        chk("rst_mid_pre_oa", fp_oa, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_oa",    fp_oa,    0);
        chk("rst_mid_cmd",   fp_cmd,   0);
        chk("rst_mid_cv",    fp_cv,    0);
        chk("rst_mid_owner", fp_owner, 0);
        chk("rst_mid_to",    fp_to,    0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("rst_mid_release_cv", fp_cv, 0);
        chk("rst_mid_release_oa", fp_oa, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_arbiter.md
CONTROL_ARBITER -- requirements
Module: control_arbiter

Interface
REQ-001 Parameter N_SRC, default 3: number of command sources (IR, mic, camera); range 2..8.
REQ-002 Parameter CMD_W, default 3: command width in bits.
REQ-003 Parameter HOLD_CYCLES, default 25_000_000: ownership hold window (0.5 s at 50 MHz).
REQ-004 Parameter TIMEOUT_CYCLES, default 100_000_000: watchdog period; must be greater than HOLD_CYCLES.
REQ-005 Parameter SAFE_CMD, default 0: command issued on watchdog expiry (stop).
REQ-006 Parameter RR_MODE, default 0: 0 selects fixed priority (lowest index wins); 1 selects round-robin.
REQ-007 clk_50  in  1  sole clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 src_valid  in  N_SRC  one-cycle command strobe per source.
REQ-010 src_cmd  in  N_SRC*CMD_W  packed commands; source i occupies bits [i*CMD_W +: CMD_W].
REQ-011 src_enable  in  N_SRC  per-source mask; a masked source is never granted.
REQ-012 cmd  out  CMD_W  current drive command, held between updates.
REQ-013 cmd_valid  out  1  one-cycle pulse whenever cmd is updated.
REQ-014 owner  out  $clog2(N_SRC)  index of the current owner.
REQ-015 owner_active  out  1  high while in state OWN.
REQ-016 timeout_flag  out  1  sticky watchdog indicator.

Function
REQ-017 The FSM SHALL have two states. IDLE means no owner. OWN means a source holds the output.
REQ-018 Latency: a strobe sampled at edge k SHALL produce updated cmd and cmd_valid=1 registered at edge k; both are visible during cycle k+1.
REQ-019 In IDLE, any enabled valid SHALL be granted per RR_MODE. On grant: state OWN, owner=winner, cmd=winner's command, cmd_valid pulse, hold counter loaded with HOLD_CYCLES-1, watchdog counter cleared.
REQ-020 In OWN with the hold counter nonzero, only the owner's strobes SHALL be accepted; other strobes are dropped.
REQ-021 Each accepted strobe SHALL reload the hold counter and clear the watchdog counter, including strobes whose command equals the current cmd.
REQ-022 In OWN with the hold counter at 0, arbitration SHALL be open: any enabled requester, including the owner, may win per RR_MODE.
REQ-023 Round-robin search SHALL start at last_grant+1 and wrap modulo N_SRC. last_grant SHALL update only on grant.
REQ-024 Watchdog: when the counter reaches TIMEOUT_CYCLES-1 with no accepted strobe, the block SHALL set cmd=SAFE_CMD, pulse cmd_valid, set timeout_flag=1 and go to IDLE.
REQ-025 timeout_flag SHALL clear on the next accepted strobe.
REQ-026 The watchdog counter SHALL also run in IDLE, but SHALL fire at most once per expiry; it saturates until the next grant.
REQ-027 If the owner's src_enable deasserts while in OWN, the block SHALL go to IDLE on the next edge. cmd is unchanged and there is no cmd_valid pulse.
REQ-028 If an owner strobe and watchdog expiry occur in the same cycle, the strobe SHALL win and no safe command is issued.
REQ-029 If hold expiry and multiple requests occur in the same cycle, the arbitration result SHALL apply. Exactly one grant per cycle.

Reset
REQ-030 rst_n low SHALL asynchronously force: state IDLE, cmd=SAFE_CMD, cmd_valid=0, owner=0, owner_active=0, timeout_flag=0, all counters 0, last_grant=N_SRC-1.
REQ-031 Reset asserted mid-hold SHALL discard ownership. No cmd_valid pulse SHALL occur during or upon release of reset.

Configuration
REQ-032 Macro CTRL_ARB_DEBOUNCE_EN defined: a strobe from source i SHALL count as a request only if its command equals that source's previous strobed command. Each source has a last-value register, cleared to SAFE_CMD on reset.
REQ-033 Macro CTRL_ARB_DEBOUNCE_EN undefined: every strobe SHALL count as a request, and no last-value registers exist.

Structure
REQ-034 Package ctrl_arb_pkg SHALL hold the state enum (IDLE, OWN), the direction command constants (including STOP=SAFE_CMD default) and the packing width helper.
REQ-035 Sub-module rr_arbiter SHALL implement the combinational grant: request vector, start index and mode in; one-hot grant plus index out. control_arbiter instantiates it once.

Verification (bench uses HOLD_CYCLES=8, TIMEOUT_CYCLES=20, N_SRC=3)
REQ-036 Fixed priority: src_valid=3'b110, cmds 5 and 6, in IDLE -> owner=1, cmd=5, cmd_valid single pulse one cycle later.
REQ-037 Hold: owner 0 granted, src 2 strobes at cycle +3 -> ignored; src 2 strobes at cycle +9 -> owner=2.
REQ-038 Round-robin (RR_MODE=1): all three strobing every 10 cycles -> grants 0,1,2,0 in order.
REQ-039 Watchdog: single grant with cmd=4, then silence -> after 20 cycles cmd=0, cmd_valid pulse, timeout_flag=1, owner_active=0; the next strobe clears the flag.
REQ-040 Mask and reset: src_enable[owner] cleared mid-hold -> IDLE next edge with no pulse; rst_n low mid-hold -> all outputs at reset values immediately.
REQ-041 Debounce (CTRL_ARB_DEBOUNCE_EN defined): src 0 strobes 3, then 3 -> only the second strobe is granted; strobes 3, 5 -> neither is granted.
